extend_pipe: RTL

Parametrised, pipelined immediate-extension unit for the CPU datapath. It widens an IN_W-bit immediate to OUT_W bits using one of four ops: zero-extend, sign-extend, load-upper, and branch-offset. Accepted items pass through a 2-stage valid/ready pipeline with full throughput and backpressure. Each item carries an opaque tag (e.g. a destination register id), so the unit can sit between decode and execute in a stall-capable pipeline.

---
 rtl/extend_pipe.sv | 96 +++++++++
 1 files changed

// File: rtl/extend_pipe.sv
// extend_pipe: 2-stage valid/ready immediate-extension unit (ZE/SE/LS/BR).
// Define EXTEND_PIPE_BR_EN to build the BR op; otherwise op 2'b11 returns 0 with op_err.
module extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ext_op,
    input  logic [IN_W-1:0]  im,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             op_err
);

    typedef struct packed {
        logic [IN_W-1:0]  im;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } s1_t;

    localparam logic [1:0] OP_ZE = 2'b00;
    localparam logic [1:0] OP_SE = 2'b01;
    localparam logic [1:0] OP_LS = 2'b10;
    localparam logic [1:0] OP_BR = 2'b11;

    logic             s1_valid;
    s1_t              s1;
    logic             s2_valid;
    logic             s2_adv;
    logic             s1_adv;
    logic [OUT_W-1:0] ze_val;
    logic [OUT_W-1:0] se_val;
    logic [OUT_W-1:0] ls_val;
    logic [OUT_W-1:0] res;
    logic             res_err;

    // Ready ripples back combinationally so a full pipe can accept while draining.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    assign ze_val = OUT_W'(s1.im);
    assign se_val = OUT_W'($signed(s1.im));
    assign ls_val = OUT_W'(s1.im) << (OUT_W - IN_W);

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        unique case (s1.op)
            OP_ZE: res = ze_val;
            OP_SE: res = se_val;
            OP_LS: res = ls_val;
`ifdef EXTEND_PIPE_BR_EN
            OP_BR: res = se_val << 2;
`else
            OP_BR: begin
                res     = '0;
                res_err = 1'b1;
            end
`endif
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1       <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            op_err   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                s1.im    <= im;
                s1.op    <= ext_op;
                s1.tag   <= in_tag;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                out_data <= res;
                out_tag  <= s1.tag;
                op_err   <= res_err;
            end
        end
    end

endmodule
